// File: rtl/shared_mem_arbiter.sv
// Purpose: load/store front-end for the dual-core data memory; round-robin
//          serialisation of conflicting shared-region accesses, registered strobes.
// Latency: store: strobe + reqReady one cycle after acceptance; load: respValid two cycles after.
// Backpressure: a core holds reqValid until reqReady; reqValid is ignored while busy.
// Ports: clk/rst; reqValid/reqWrite/reqADDRx/reqDATAx (request), reqReady,
//        respValid/respDATAx (load return), errFlag (sticky range error),
//        dataINx/dataADDRx/dataWrite/dataLoad (memory drive), dataOUTx (memory read data).
module shared_mem_arbiter #(
  parameter int Ncores = 2,
  parameter int Lmem   = 8,
  parameter int TAM    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Ncores-1:0] reqValid,
  input  logic [Ncores-1:0] reqWrite,
  input  logic [TAM-1:0]    reqADDR0,
  input  logic [TAM-1:0]    reqADDR1,
  input  logic [TAM-1:0]    reqDATA0,
  input  logic [TAM-1:0]    reqDATA1,
  output logic [Ncores-1:0] reqReady,
  output logic [Ncores-1:0] respValid,
  output logic [TAM-1:0]    respDATA0,
  output logic [TAM-1:0]    respDATA1,
  output logic [Ncores-1:0] errFlag,
  output logic [TAM-1:0]    dataIN0,
  output logic [TAM-1:0]    dataIN1,
  output logic [TAM-1:0]    dataADDR0,
  output logic [TAM-1:0]    dataADDR1,
  output logic [Ncores-1:0] dataWrite,
  output logic [Ncores-1:0] dataLoad,
  input  logic [TAM-1:0]    dataOUT0,
  input  logic [TAM-1:0]    dataOUT1
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state     [Ncores];
  state_t            stateNext [Ncores];
  logic [TAM-1:0]    reqAddr   [Ncores];
  logic [TAM-1:0]    reqData   [Ncores];
  logic [TAM-1:0]    memOut    [Ncores];
  logic [TAM-1:0]    addrQ     [Ncores];
  logic [TAM-1:0]    dinQ      [Ncores];
  logic [TAM-1:0]    respQ     [Ncores];
  logic [Ncores-1:0] writeQ;
  logic [Ncores-1:0] rejQ;
  logic [Ncores-1:0] errQ;
  logic [Ncores-1:0] cand;
  logic [Ncores-1:0] shared;
  logic [Ncores-1:0] outOfRange;
  logic [Ncores-1:0] accept;
  logic [Ncores-1:0] reject;
  logic              conflict;
  logic              winner;
  logic              rrLast;

  assign reqAddr[0] = reqADDR0;
  assign reqAddr[1] = reqADDR1;
  assign reqData[0] = reqDATA0;
  assign reqData[1] = reqDATA1;
  assign memOut[0]  = dataOUT0;
  assign memOut[1]  = dataOUT1;

  // Request qualification, arbitration and next state.
  always_comb begin
    conflict   = 1'b0;
    winner     = ~rrLast;
    cand       = '0;
    shared     = '0;
    outOfRange = '0;
    accept     = '0;
    reject     = '0;
    for (int i = 0; i < Ncores; i++) begin
      stateNext[i] = state[i];
    end
    for (int i = 0; i < Ncores; i++) begin
      outOfRange[i] = |reqAddr[i][TAM-1:Lmem+1];
      // The cycle a rejection is reported the core is still presenting the
      // rejected request, so it must not be evaluated a second time.
      cand[i]   = (state[i] == IDLE) && reqValid[i] && !rejQ[i];
      shared[i] = cand[i] && !outOfRange[i] && reqAddr[i][Lmem];
    end
    // Two shared loads can proceed together; any store among them serialises.
    conflict = (&shared) && (|reqWrite);
    for (int i = 0; i < Ncores; i++) begin
      reject[i] = cand[i] && outOfRange[i];
      accept[i] = cand[i] && !outOfRange[i] && (!conflict || (winner == 1'(i)));
      unique case (state[i])
        IDLE:    if (accept[i]) stateNext[i] = ISSUE;
        ISSUE:   stateNext[i] = writeQ[i] ? IDLE : RESP;
        RESP:    stateNext[i] = IDLE;
        default: stateNext[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Ncores; i++) begin
        state[i] <= IDLE;
        addrQ[i] <= '0;
        dinQ[i]  <= '0;
        respQ[i] <= '0;
      end
      writeQ <= '0;
      rejQ   <= '0;
      errQ   <= '0;
      rrLast <= 1'b1;
    end else begin
      for (int i = 0; i < Ncores; i++) begin
        state[i] <= stateNext[i];
        if (accept[i]) begin
          addrQ[i]  <= reqAddr[i];
          dinQ[i]   <= reqData[i];
          writeQ[i] <= reqWrite[i];
        end
        // Memory read data is valid during the load strobe cycle.
        if (state[i] == ISSUE && !writeQ[i]) begin
          respQ[i] <= memOut[i];
        end
      end
      rejQ <= reject;
      errQ <= errQ | reject;
      if (conflict) begin
        rrLast <= winner;
      end
    end
  end

  always_comb begin
    reqReady  = '0;
    respValid = '0;
    dataWrite = '0;
    dataLoad  = '0;
    for (int i = 0; i < Ncores; i++) begin
      reqReady[i]  = (state[i] == ISSUE) || rejQ[i];
      respValid[i] = (state[i] == RESP);
      dataWrite[i] = (state[i] == ISSUE) && writeQ[i];
      dataLoad[i]  = (state[i] == ISSUE) && !writeQ[i];
    end
  end

  assign errFlag   = errQ;
  assign dataADDR0 = addrQ[0];
  assign dataADDR1 = addrQ[1];
  assign dataIN0   = dinQ[0];
  assign dataIN1   = dinQ[1];
  assign respDATA0 = respQ[0];
  assign respDATA1 = respQ[1];

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed scenarios then random traffic, every
// cycle compared against a timestamp-based reference model.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv, rw;
  logic [15:0] rAddr [2];
  logic [15:0] rDat  [2];
  logic [1:0]  reqReady, respValid, errFlag, dataWrite, dataLoad;
  logic [15:0] respDATA0, respDATA1, dataIN0, dataIN1, dataADDR0, dataADDR1;
  logic [15:0] dataOUT0, dataOUT1;

  shared_mem_arbiter #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
    .clk(clk), .rst(rst),
    .reqValid(rv), .reqWrite(rw),
    .reqADDR0(rAddr[0]), .reqADDR1(rAddr[1]),
    .reqDATA0(rDat[0]), .reqDATA1(rDat[1]),
    .reqReady(reqReady), .respValid(respValid),
    .respDATA0(respDATA0), .respDATA1(respDATA1),
    .errFlag(errFlag),
    .dataIN0(dataIN0), .dataIN1(dataIN1),
    .dataADDR0(dataADDR0), .dataADDR1(dataADDR1),
    .dataWrite(dataWrite), .dataLoad(dataLoad),
    .dataOUT0(dataOUT0), .dataOUT1(dataOUT1)
  );

  always #5 clk = ~clk;

  // Shared region is common to both cores; each core has its own private bank.
  function automatic int keyOf(input int c, input logic [15:0] a);
    if (a[8]) return int'(a[8:0]);
    return 512 + c * 256 + int'(a[7:0]);
  endfunction

  // Memory: asynchronous read, write committed at the falling edge of the strobe cycle.
  logic [15:0] mem [1024];
  assign dataOUT0 = mem[keyOf(0, dataADDR0)];
  assign dataOUT1 = mem[keyOf(1, dataADDR1)];
  always @(negedge clk) begin
    if (dataWrite[0]) mem[keyOf(0, dataADDR0)] <= dataIN0;
    if (dataWrite[1]) mem[keyOf(1, dataADDR1)] <= dataIN1;
  end

  // Reference model: per core, the cycle of its strobe, the cycle of its
  // rejection report and the last cycle it is busy.
  int          k;
  int          issueAt  [2];
  int          rejAt    [2];
  int          lastBusy [2];
  bit          isW      [2];
  logic [15:0] lastAddr [2];
  logic [15:0] lastDat  [2];
  logic [15:0] expResp  [2];
  logic [15:0] pendLoad [2];
  logic [15:0] refMem   [1024];
  logic [1:0]  errM;
  int          rrM;
  int          nTests = 0;
  int          nFail  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      issueAt[c]  = -10;
      rejAt[c]    = -10;
      lastBusy[c] = -10;
      isW[c]      = 1'b1;
      lastAddr[c] = '0;
      lastDat[c]  = '0;
      expResp[c]  = '0;
      pendLoad[c] = '0;
    end
    errM = '0;
    rrM  = 1;
  endtask

  task automatic compareAll();
    logic [1:0] eRR, eRV, eDW, eDL;
    for (int c = 0; c < 2; c++) begin
      eRR[c] = (k == issueAt[c]) || (k == rejAt[c]);
      eDW[c] = (k == issueAt[c]) && isW[c];
      eDL[c] = (k == issueAt[c]) && !isW[c];
      eRV[c] = (k == issueAt[c] + 1) && !isW[c];
    end
    check("reqReady",  16'(reqReady),  16'(eRR));
    check("respValid", 16'(respValid), 16'(eRV));
    check("dataWrite", 16'(dataWrite), 16'(eDW));
    check("dataLoad",  16'(dataLoad),  16'(eDL));
    check("errFlag",   16'(errFlag),   16'(errM));
    check("dataADDR0", dataADDR0, lastAddr[0]);
    check("dataADDR1", dataADDR1, lastAddr[1]);
    check("dataIN0",   dataIN0,   lastDat[0]);
    check("dataIN1",   dataIN1,   lastDat[1]);
    check("respDATA0", respDATA0, expResp[0]);
    check("respDATA1", respDATA1, expResp[1]);
  endtask

  // Model acceptance at the coming edge from the inputs presented now.
  task automatic decide();
    bit idle [2];
    bit cand [2];
    bit oor  [2];
    bit sh   [2];
    bit conf;
    int win;
    for (int c = 0; c < 2; c++) begin
      idle[c] = (k > lastBusy[c]) && (k != rejAt[c]);
      cand[c] = idle[c] && rv[c];
      oor[c]  = (rAddr[c][15:9] != 7'd0);
      sh[c]   = cand[c] && !oor[c] && rAddr[c][8];
    end
    conf = sh[0] && sh[1] && (rw != 2'b00);
    win  = 1 - rrM;
    for (int c = 0; c < 2; c++) begin
      if (cand[c]) begin
        if (oor[c]) begin
          rejAt[c] = k + 1;
          errM[c]  = 1'b1;
        end else if (!conf || c == win) begin
          issueAt[c]  = k + 1;
          isW[c]      = rw[c];
          lastBusy[c] = rw[c] ? k + 1 : k + 2;
          lastAddr[c] = rAddr[c];
          lastDat[c]  = rDat[c];
        end
      end
    end
    if (conf) rrM = win;
  endtask

  task automatic step();
    decide();
    @(posedge clk);
    #1;
    k++;
    for (int c = 0; c < 2; c++)
      if (k == issueAt[c] && isW[c]) refMem[keyOf(c, lastAddr[c])] = lastDat[c];
    for (int c = 0; c < 2; c++) begin
      if (k == issueAt[c] && !isW[c])     pendLoad[c] = refMem[keyOf(c, lastAddr[c])];
      if (k == issueAt[c] + 1 && !isW[c]) expResp[c]  = pendLoad[c];
    end
    compareAll();
    // A request is withdrawn once its reqReady is seen.
    for (int c = 0; c < 2; c++)
      if (k == issueAt[c] || k == rejAt[c]) rv[c] = 1'b0;
  endtask

  task automatic setReq(input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
    rv[c]    = 1'b1;
    rw[c]    = w;
    rAddr[c] = a;
    rDat[c]  = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    rv = '0;
    compareAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = '0;
      refMem[i] = '0;
    end
    k = 0;
    rst = 1'b1;
    rv = '0;
    rw = '0;
    rAddr[0] = '0; rAddr[1] = '0;
    rDat[0]  = '0; rDat[1]  = '0;
    modelReset();
    #2;
    compareAll();
    @(negedge clk);
    rst = 1'b0;

    // Private store then load on core 0.
    setReq(0, 1'b1, 16'h0005, 16'h1234);
    step();
    check("plan_store_dw", 16'(dataWrite), 16'h0001);
    check("plan_store_rdy", 16'(reqReady), 16'h0001);
    step();
    setReq(0, 1'b0, 16'h0005, 16'h0000);
    step();
    check("plan_load_dl", 16'(dataLoad), 16'h0001);
    step();
    check("plan_load_rv", 16'(respValid), 16'h0001);
    check("plan_load_data", respDATA0, 16'h1234);
    step();

    // Conflicting shared stores, twice: core 0 wins first, core 1 next.
    setReq(0, 1'b1, 16'h0110, 16'hAAAA);
    setReq(1, 1'b1, 16'h0120, 16'hBBBB);
    step();
    check("rr1_first", 16'(dataWrite), 16'h0001);
    step();
    check("rr1_second", 16'(dataWrite), 16'h0002);
    step();
    setReq(0, 1'b1, 16'h0110, 16'hAAAA);
    setReq(1, 1'b1, 16'h0120, 16'hBBBB);
    step();
    check("rr2_first", 16'(dataWrite), 16'h0002);
    step();
    check("rr2_second", 16'(dataWrite), 16'h0001);
    step();

    // Simultaneous shared loads proceed together.
    setReq(0, 1'b0, 16'h0101, 16'h0000);
    setReq(1, 1'b0, 16'h0101, 16'h0000);
    step();
    check("shload_dl", 16'(dataLoad), 16'h0003);
    step();
    check("shload_rv", 16'(respValid), 16'h0003);
    step();

    // Out-of-range request from core 1.
    setReq(1, 1'b0, 16'h0300, 16'h0000);
    step();
    check("oor_rdy", 16'(reqReady), 16'h0002);
    check("oor_strobe", 16'(dataLoad | dataWrite), 16'h0000);
    check("oor_err", 16'(errFlag), 16'h0002);
    step();
    step();
    check("oor_err_sticky", 16'(errFlag), 16'h0002);

    // Reset during a core 0 load strobe.
    setReq(0, 1'b0, 16'h0005, 16'h0000);
    step();
    check("rst_pre_dl", 16'(dataLoad), 16'h0001);
    doReset();
    check("rst_dl", 16'(dataLoad), 16'h0000);
    check("rst_err", 16'(errFlag), 16'h0000);
    step();
    check("rst_rv", 16'(respValid), 16'h0000);
    setReq(0, 1'b1, 16'h0130, 16'h1111);
    setReq(1, 1'b1, 16'h0140, 16'h2222);
    step();
    check("rst_rr", 16'(dataWrite), 16'h0001);
    step();
    step();

    // Private store and private load in the same cycle.
    setReq(0, 1'b1, 16'h0010, 16'h5555);
    setReq(1, 1'b0, 16'h0020, 16'h0000);
    step();
    check("priv_dw", 16'(dataWrite), 16'h0001);
    check("priv_dl", 16'(dataLoad), 16'h0002);
    step();
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) doReset();
      for (int c = 0; c < 2; c++) begin
        if (!rv[c] && $urandom_range(0, 1) == 1) begin
          a = {7'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7))};
          if ($urandom_range(0, 15) == 0) a[15:9] = 7'($urandom_range(1, 127));
          setReq(c, 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Request front-end for the dual-core data memory. Accepts load/store requests from core 0 and core 1 over a valid/ready handshake, serialises conflicting shared-region accesses with a round-robin grant, and drives the memory's per-core dataIN/dataADDR/dataWrite/dataLoad ports as one-cycle registered strobes. Load results are captured from dataOUT0/dataOUT1 and returned to the issuing core with a one-cycle response pulse.

## Interface
- Ncores, 2, number of cores; fixed at 2.
- Lmem, 8, private/shared bank index width; address bit Lmem selects the shared region.
- TAM, 16, data and address width.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reqValid  in  Ncores  request present, one bit per core.
- reqWrite  in  Ncores  1 = store, 0 = load.
- reqADDR0, reqADDR1  in  TAM  request address per core.
- reqDATA0, reqDATA1  in  TAM  store data per core.
- reqReady  out  Ncores  one-cycle pulse: request consumed.
- respValid  out  Ncores  one-cycle pulse: load data valid.
- respDATA0, respDATA1  out  TAM  load data; held until the next load response.
- errFlag  out  Ncores  sticky out-of-range address flag.
- dataIN0, dataIN1  out  TAM  memory store data.
- dataADDR0, dataADDR1  out  TAM  memory address.
- dataWrite, dataLoad  out  Ncores  memory strobes.
- dataOUT0, dataOUT1  in  TAM  memory load data.

## Operation
- Per-core FSM: IDLE, ISSUE, RESP.
- Shared request: reqValid[i] & reqADDRi[Lmem].
- Conflict: both cores issue shared requests in the same IDLE cycle and at least one is a store.
- IDLE, reqValid[i], no conflict loss: latch address/data, go to ISSUE.
- Conflict loser stays in IDLE; its request is re-evaluated on the next cycle.
- Round-robin pointer rrLast: the winner is the core that is not rrLast. rrLast updates to the winner on every conflict. It is unchanged when there is no conflict.
- Range check in IDLE: if reqADDRi[TAM-1:Lmem+1] != 0, the request is rejected.
  - reqReady[i] pulses; errFlag[i] is set.
  - No strobe is issued; the FSM stays in IDLE.
- ISSUE: dataWrite[i] or dataLoad[i] is high for exactly this cycle, with dataADDRi/dataINi stable.
  - reqReady[i] is high in this cycle.
  - Store: next state is IDLE.
  - Load: next state is RESP.
- RESP: respValid[i] = 1; respDATAi = dataOUTi sampled at the rising edge ending ISSUE. Next state is IDLE.
- Private accesses (bit Lmem = 0) never arbitrate; both cores may issue in the same cycle.
- Two shared loads in the same cycle are not a conflict; both issue.
- dataADDRi/dataINi hold their last value outside ISSUE; strobes are 0 outside ISSUE.

## Timing
- Reset (async, immediate):
  - All FSMs go to IDLE; rrLast = 1, so core 0 wins the first conflict.
  - All outputs 0: reqReady, respValid, respDATA0/1, errFlag, dataIN0/1, dataADDR0/1, dataWrite, dataLoad.
- Store latency: request accepted at edge N; strobe and reqReady in cycle N+1; core free again at cycle N+2.
- Load latency: accepted at edge N; strobe in cycle N+1; respValid in cycle N+2; next accept is possible at edge N+3.
- Max rate per core: a store every 2 cycles, a load every 3 cycles.
- Conflict loser: its strobe is at least 1 cycle later than the winner's. It wins the following conflict if the pair repeats, so there is no starvation.
- reqValid is ignored outside IDLE; the core must hold the request until reqReady.
- Reset mid-ISSUE or mid-RESP: strobes and respValid drop immediately; the partially issued access is not retried; errFlag clears.
- Rejected request: reqReady pulses in the cycle after acceptance (N+1), with no strobe.

## Test plan
- Reset, then core 0 stores 0x1234 to 0x0005 → cycle N+1: dataWrite = 01, dataADDR0 = 0x0005, dataIN0 = 0x1234, reqReady = 01; then core 0 loads 0x0005 with memory returning 0x1234 → respValid[0] one cycle after dataLoad[0], respDATA0 = 0x1234.
- Both cores store simultaneously to shared 0x0110 (0xAAAA) and 0x0120 (0xBBBB) → core 0 strobes first, core 1 one cycle later. Repeat the pair → core 1 strobes first.
- Both cores load shared 0x0101 simultaneously → dataLoad = 11 in the same cycle, and both respValid pulse together.
- Core 1 requests 0x0300 (bit 9 set) → reqReady[1] pulses, dataLoad/dataWrite stay 0, errFlag = 10 and persists until rst.
- Assert rst during a core 0 load ISSUE cycle → dataLoad drops immediately, respValid stays 0, all outputs 0; the next conflict is won by core 0.
- Private store from core 0 and private load from core 1 in the same cycle → dataWrite = 01 and dataLoad = 10 in the same cycle, with no stall.
